// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// Holds the arbitration state encoding and the channel-index width function.
package rr_mux_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Channel index width; never below one bit so a 1-bit out_ch always exists.
    function automatic int ch_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Stream bundle for rr_stream_mux: N_CH input channels and one merged output.
// The slave modport is the multiplexer's view, master is the environment's view.
interface rr_stream_mux_if
    import rr_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = ch_w(N_CH)
);

    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_last;
    logic [N_CH-1:0]        in_ready;

    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_ready;
    logic [CH_W-1:0]        out_ch;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_ch
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with packet lock: searches from ptr upward with wrap,
// or forces the grant to lock_ch while a packet is in flight.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            lock_en,
    input  logic [CH_W-1:0] lock_ch,
    output logic [N_CH-1:0] grant
);

    int   idx_s;
    logic found_s;
    logic hit_s;

    // One-hot grant: locked channel wins outright, otherwise first requester from ptr.
    always_comb begin
        grant   = '0;
        idx_s   = 0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        if (lock_en) begin
            for (int i = 0; i < N_CH; i++) begin
                grant[i] = (lock_ch == CH_W'(i));
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                idx_s        = (int'(ptr) + k) % N_CH;
                hit_s        = req[idx_s] & ~found_s;
                grant[idx_s] = hit_s;
                found_s      = found_s | hit_s;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux_chk.sv
// Protocol checker for rr_stream_mux: grant shape and output back-pressure rules.
module rr_stream_mux_chk #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = 2
) (
    input logic              clk,
    input logic              rst_n,
    input logic [N_CH-1:0]   grant,
    input logic [N_CH-1:0]   in_ready,
    input logic [DATA_W-1:0] out_data,
    input logic              out_valid,
    input logic              out_last,
    input logic              out_ready,
    input logic [CH_W-1:0]   out_ch
);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant));

    a_stall_no_ready: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |-> (in_ready == '0));

    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=>
        (out_valid && $stable(out_data) && $stable(out_ch) && $stable(out_last)));

endmodule

// File: rtl/rr_stream_mux.sv
// N_CH-to-1 stream multiplexer with round-robin arbitration, optional packet
// locking, and a single registered output stage (one-cycle latency).
module rr_stream_mux
    import rr_mux_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 8,
    parameter int LOCK_PKT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_stream_mux_if.slave    bus
);

    localparam int CH_W = ch_w(N_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]     lock_ch_q, lock_ch_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;

    logic [N_CH-1:0]     grant_s;
    logic                lock_en_s;
    logic                load_s;
    logic                accept_s;
    logic [CH_W-1:0]     g_idx_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                sel_last_s;

    function automatic logic [CH_W-1:0] inc_mod(input logic [CH_W-1:0] ch);
        return (ch == LAST_CH) ? '0 : ch + CH_ONE;
    endfunction

    // Reset gates load so no channel sees ready while the block is held in reset.
    assign load_s       = rst_n & (~out_valid_q | bus.out_ready);
    assign lock_en_s    = (state_q == LOCK);
    assign bus.in_ready = grant_s & {N_CH{load_s}};
    assign accept_s     = load_s & (|(grant_s & bus.in_valid));

    rr_arbiter #(
        .N_CH    (N_CH),
        .CH_W    (CH_W)
    ) u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .lock_en (lock_en_s),
        .lock_ch (lock_ch_q),
        .grant   (grant_s)
    );

    // Encode the one-hot grant into the channel index used for selection.
    always_comb begin
        g_idx_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            g_idx_s = g_idx_s | (grant_s[i] ? CH_W'(i) : '0);
        end
    end

    assign sel_data_s = bus.in_data[int'(g_idx_s)*DATA_W +: DATA_W];
    assign sel_last_s = bus.in_last[g_idx_s];

    // Next-state logic for the output register, pointer and packet-lock FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_ch_d   = lock_ch_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;

        if (load_s) begin
            out_valid_d = accept_s;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            out_data_d = sel_data_s;
            out_last_d = sel_last_s;
            out_ch_d   = g_idx_s;
            if (LOCK_PKT == 32'sd0) begin
                state_d = ARB;
                ptr_d   = inc_mod(g_idx_s);
            end else begin
                case (state_q)
                    ARB: begin
                        if (sel_last_s) begin
                            ptr_d = inc_mod(g_idx_s);
                        end else begin
                            state_d   = LOCK;
                            lock_ch_d = g_idx_s;
                        end
                    end
                    LOCK: begin
                        if (sel_last_s) begin
                            state_d = ARB;
                            ptr_d   = inc_mod(lock_ch_q);
                        end else begin
                            state_d = LOCK;
                        end
                    end
                    default: begin
                        state_d = ARB;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; reset drops any held lock and restarts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            lock_ch_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_ch_q   <= lock_ch_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_ch    = out_ch_q;

    rr_stream_mux_chk #(
        .N_CH      (N_CH),
        .DATA_W    (DATA_W),
        .CH_W      (CH_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (grant_s),
        .in_ready  (bus.in_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_last  (bus.out_last),
        .out_ready (bus.out_ready),
        .out_ch    (bus.out_ch)
    );

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: three instances cover per-beat arbitration,
// packet locking with back-pressure and reset, and a 16-channel wrap case.
module tb_rr_stream_mux;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_stream_mux_if #(.N_CH(4),  .DATA_W(8))  if0 ();
    rr_stream_mux_if #(.N_CH(4),  .DATA_W(8))  if1 ();
    rr_stream_mux_if #(.N_CH(16), .DATA_W(32)) if2 ();

    rr_stream_mux #(.N_CH(4), .DATA_W(8), .LOCK_PKT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    rr_stream_mux #(.N_CH(4), .DATA_W(8), .LOCK_PKT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );
    rr_stream_mux #(.N_CH(16), .DATA_W(32), .LOCK_PKT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2)
    );

    int n_total = 0;
    int n_bad   = 0;
    int acc0    = 0;
    int snap0;

    // Count beats accepted on any input channel of the per-beat instance.
    always @(posedge clk) begin
        if (|(if0.in_valid & if0.in_ready)) acc0 <= acc0 + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        if0.in_data = '0; if0.in_valid = '0; if0.in_last = '0; if0.out_ready = 1'b1;
        if1.in_data = '0; if1.in_valid = '0; if1.in_last = '0; if1.out_ready = 1'b1;
        if2.in_data = '0; if2.in_valid = '0; if2.in_last = '0; if2.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) if2.in_data[i*32 +: 32] = 32'hD000_0000 | 32'(i);

        // Reset state, with requests present to show in_ready is gated.
        #2;
        if0.in_valid = 4'hF;
        #1;
        check_eq("rst_in_ready",  64'(if0.in_ready),  64'h0);
        check_eq("rst_out_valid", 64'(if0.out_valid), 64'h0);
        check_eq("rst_out_data",  64'(if0.out_data),  64'h0);
        check_eq("rst_out_ch",    64'(if0.out_ch),    64'h0);
        check_eq("rst_out_last",  64'(if0.out_last),  64'h0);
        check_eq("rst_valid16",   64'(if2.out_valid), 64'h0);

        // Per-beat round robin, all channels valid.
        @(negedge clk);
        rst_n = 1'b1;
        if0.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        check_eq("s1_ready0", 64'(if0.in_ready), 64'h1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("s1_valid", 64'(if0.out_valid), 64'h1);
            check_eq("s1_ch",    64'(if0.out_ch),    64'(i % 4));
            check_eq("s1_data",  64'(if0.out_data),  64'h10 + 64'(i % 4));
            check_eq("s1_ready", 64'(if0.in_ready),  64'(1 << ((i + 1) % 4)));
        end

        // Output back-pressure for five cycles.
        if0.out_ready = 1'b0;
        snap0 = acc0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("s3_valid", 64'(if0.out_valid), 64'h1);
            check_eq("s3_data",  64'(if0.out_data),  64'h11);
            check_eq("s3_ch",    64'(if0.out_ch),    64'h1);
            check_eq("s3_ready", 64'(if0.in_ready),  64'h0);
        end
        check_eq("s3_acc", 64'(acc0), 64'(snap0));
        if0.out_ready = 1'b1;
        #1;
        check_eq("s3_resume_ready", 64'(if0.in_ready), 64'h4);
        step();
        check_eq("s3_resume_ch",   64'(if0.out_ch),   64'h2);
        check_eq("s3_resume_data", 64'(if0.out_data), 64'h12);
        if0.in_valid = 4'h0;
        step();
        check_eq("drain_valid", 64'(if0.out_valid), 64'h0);
        if0.in_valid = 4'h8;
        if0.in_last  = 4'h8;
        step();
        check_eq("pass_last_ch",   64'(if0.out_ch),   64'h3);
        check_eq("pass_last",      64'(if0.out_last), 64'h1);
        check_eq("pass_last_v",    64'(if0.out_valid), 64'h1);
        if0.in_valid = 4'h0;
        if0.in_last  = 4'h0;

        // Packet lock: single-beat ch1 moves ptr to 2, then ch2 sends a 3-beat packet.
        if1.in_data = {8'hC0, 8'hA0, 8'hB0, 8'h50};
        if1.in_valid = 4'b0010;
        if1.in_last  = 4'b0010;
        step();
        check_eq("s2_pre_ch",   64'(if1.out_ch),   64'h1);
        check_eq("s2_pre_last", 64'(if1.out_last), 64'h1);
        if1.in_valid = 4'b0101;
        if1.in_last  = 4'b0000;
        #1;
        check_eq("s2_ready_a", 64'(if1.in_ready), 64'h4);
        step();
        check_eq("s2_ch_a",   64'(if1.out_ch),   64'h2);
        check_eq("s2_data_a", 64'(if1.out_data), 64'hA0);
        if1.in_data[23:16] = 8'hA1;
        #1;
        check_eq("s2_ready_b", 64'(if1.in_ready), 64'h4);
        step();
        check_eq("s2_ch_b",   64'(if1.out_ch),   64'h2);
        check_eq("s2_data_b", 64'(if1.out_data), 64'hA1);
        if1.in_data[23:16] = 8'hA2;
        if1.in_last = 4'b0100;
        step();
        check_eq("s2_ch_c",   64'(if1.out_ch),   64'h2);
        check_eq("s2_data_c", 64'(if1.out_data), 64'hA2);
        check_eq("s2_last_c", 64'(if1.out_last), 64'h1);
        check_eq("s2_ptr",    64'(dut1.ptr_q),   64'h3);
        if1.in_valid = 4'b0001;
        if1.in_last  = 4'b0001;
        step();
        check_eq("s2_ch_d",   64'(if1.out_ch),   64'h0);
        check_eq("s2_data_d", 64'(if1.out_data), 64'h50);

        // Locked channel 1 stalls for two cycles while channel 3 waits.
        if1.in_valid = 4'b1010;
        if1.in_last  = 4'b0000;
        step();
        check_eq("s4_ch_first", 64'(if1.out_ch), 64'h1);
        if1.in_valid = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("s4_ready3", 64'(if1.in_ready[3]), 64'h0);
            step();
            check_eq("s4_stall_valid", 64'(if1.out_valid), 64'h0);
        end
        if1.in_valid = 4'b1010;
        if1.in_last  = 4'b0010;
        if1.in_data[15:8] = 8'hB1;
        step();
        check_eq("s4_end_ch",   64'(if1.out_ch),   64'h1);
        check_eq("s4_end_data", 64'(if1.out_data), 64'hB1);
        check_eq("s4_end_last", 64'(if1.out_last), 64'h1);
        if1.in_last = 4'b0000;
        step();
        check_eq("s4_ch3",      64'(if1.out_ch),   64'h3);
        check_eq("s4_ch3_data", 64'(if1.out_data), 64'hC0);

        // Asynchronous reset while channel 3 holds the lock.
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("s5_valid", 64'(if1.out_valid), 64'h0);
        check_eq("s5_ready", 64'(if1.in_ready),  64'h0);
        check_eq("s5_ch",    64'(if1.out_ch),    64'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check_eq("s5_post_ready", 64'(if1.in_ready), 64'h2);
        step();
        check_eq("s5_post_ch",   64'(if1.out_ch),   64'h1);
        check_eq("s5_post_data", 64'(if1.out_data), 64'hB1);
        if1.in_valid = 4'b0000;

        // Sixteen channels: move ptr to 15, then wrap to channel 0.
        if2.in_valid = 16'h4000;
        if2.in_last  = 16'h4000;
        step();
        check_eq("s6_ch14", 64'(if2.out_ch), 64'hE);
        if2.in_valid = 16'h8008;
        if2.in_last  = 16'h8008;
        #1;
        check_eq("s6_ready15", 64'(if2.in_ready), 64'h8000);
        step();
        check_eq("s6_ch15",   64'(if2.out_ch),   64'hF);
        check_eq("s6_data15", 64'(if2.out_data), 64'hD000_000F);
        check_eq("s6_ptr",    64'(dut2.ptr_q),   64'h0);
        if2.in_valid = 16'h8001;
        if2.in_last  = 16'h8001;
        #1;
        check_eq("s6_ready0", 64'(if2.in_ready), 64'h0001);
        step();
        check_eq("s6_ch0",   64'(if2.out_ch),   64'h0);
        check_eq("s6_data0", 64'(if2.out_data), 64'hD000_0000);
        if2.in_valid = '0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning number of input channels (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning data width per channel (1..64).
REQ-003 The block SHALL have parameter LOCK_PKT, default 1, meaning 1 = hold grant until the end of a packet, 0 = re-arbitrate every beat.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_data, input, N_CH*DATA_W bits: channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have ports in_valid, in_last and in_ready (output), each N_CH bits, one bit per channel.
REQ-008 The block SHALL have port out_data, output, DATA_W bits.
REQ-009 The block SHALL have ports out_valid (output), out_last (output) and out_ready (input), each 1 bit.
REQ-010 The block SHALL have port out_ch, output, CH_W = max(1, clog2(N_CH)) bits: the source channel of the current output beat.

Function
REQ-011 A beat SHALL transfer on a channel or on the output only in a cycle where its valid and ready are both 1 at the rising clk edge.
REQ-012 The output stage SHALL be one register: out_data, out_last, out_ch and out_valid.
REQ-013 Signal load SHALL equal (!out_valid || out_ready).
REQ-014 in_ready[i] SHALL equal load && grant[i], combinationally, with no dependency of in_ready on in_valid of the same channel.
REQ-015 grant SHALL be one-hot or zero; it is zero when no candidate channel is valid.
REQ-016 In state ARB, grant SHALL select the first channel with in_valid = 1, searching ptr, ptr+1, ... with wrap modulo N_CH.
REQ-017 In state LOCK, grant SHALL be forced to lock_ch, regardless of in_valid on other channels.
REQ-018 Latency SHALL be exactly 1 cycle: a beat accepted at edge k appears on out_* immediately after edge k.
REQ-019 Throughput SHALL be 1 beat per cycle while out_ready = 1 and a granted channel is valid.
REQ-020 While out_valid = 1 and out_ready = 0, all out_* outputs SHALL hold stable and every in_ready bit SHALL be 0.
REQ-021 If out_valid = 1, out_ready = 1 and no channel is granted-and-valid, out_valid SHALL fall to 0 at the next edge.
REQ-022 On every accepted beat with LOCK_PKT = 0, ptr SHALL become (g+1) mod N_CH, where g is the granted channel.
REQ-023 With LOCK_PKT = 1 in ARB, an accepted beat with in_last = 0 SHALL move the FSM to LOCK with lock_ch = g and leave ptr unchanged.
REQ-024 With LOCK_PKT = 1 in ARB, an accepted beat with in_last = 1 SHALL keep the FSM in ARB and set ptr = (g+1) mod N_CH.
REQ-025 In LOCK, an accepted beat with in_last = 1 SHALL return the FSM to ARB and set ptr = (lock_ch+1) mod N_CH.
REQ-026 In LOCK, if the locked channel deasserts in_valid, the block SHALL stall with no grant to any other channel.
REQ-027 With LOCK_PKT = 0, in_last SHALL be passed through to out_last and the FSM SHALL never leave ARB.

Reset
REQ-028 While rst_n = 0, the block SHALL asynchronously set out_valid = 0, out_last = 0, out_data = 0, out_ch = 0, ptr = 0 and state = ARB, and SHALL clear lock_ch.
REQ-029 While rst_n = 0, in_ready SHALL be all 0, i.e. load is gated by reset.
REQ-030 A reset mid-packet SHALL discard the lock; after release, arbitration SHALL start from channel 0.
REQ-031 Reset deassertion SHALL be synchronised externally; the block SHALL NOT add a reset synchroniser.

Structure
REQ-032 The shared package rr_mux_pkg SHALL hold the state enum (ARB, LOCK) and the clog2-based CH_W width function.
REQ-033 Arbitration SHALL be implemented in sub-module rr_arbiter, parametrised on N_CH, with inputs req, ptr, lock_en and lock_ch, and output grant.
REQ-034 Data selection SHALL be an indexed part-select on the granted channel, with no chain of 2:1 stages.

Verification
REQ-035 Scenario 1: N_CH=4, LOCK_PKT=0, all channels valid with data 8'h10+i, out_ready=1 -> out_ch sequence 0,1,2,3,0,..., one beat per cycle.
REQ-036 Scenario 2: LOCK_PKT=1; channel 2 sends 3 beats with last on the 3rd; channel 0 is valid throughout -> out_ch = 2,2,2,0; ptr = 3 after the packet.
REQ-037 Scenario 3: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_ch stable and in_ready=0 throughout; accepted-beat count unchanged.
REQ-038 Scenario 4: LOCK, channel 1 drops valid for 2 cycles while channel 3 is valid -> no channel-3 beat until channel 1 sends last.
REQ-039 Scenario 5: rst_n pulsed low mid-packet (asynchronously, between edges) -> out_valid=0 immediately; after release, the first grant is the lowest valid channel from 0.
REQ-040 Scenario 6: N_CH=16, DATA_W=32, only channel 15 valid, ptr=15 -> grant wraps correctly; the next grant goes to channel 0 when it becomes valid.
